// File: rtl/hello_world_qsys_ram_tester_pkg.sv
// ============================================================================
// hello_world_qsys_ram_tester_pkg : shared state encoding and constants
// Revision: 1.0
// ============================================================================
`default_nettype none

package hello_world_qsys_ram_tester_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [31:0] PAT_STEP_DEFAULT = 32'h9E37_79B9;
  localparam logic [15:0] ERR_SAT          = 16'hFFFF;

endpackage

`default_nettype wire

// File: rtl/hello_world_qsys_ram_tester_rdpipe.sv
// ============================================================================
// hello_world_qsys_ram_tester_rdpipe : fixed-latency tracker of outstanding reads
// Revision: 1.0
// ============================================================================
`default_nettype none

module hello_world_qsys_ram_tester_rdpipe
  import hello_world_qsys_ram_tester_pkg::*;
#(
  parameter int READ_LATENCY = 1,
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_i,
  input  logic [DATA_W-1:0] exp_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] exp_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              empty_o
);

  logic [READ_LATENCY-1:0] valid_q;
  logic [DATA_W-1:0]       exp_q  [READ_LATENCY];
  logic [ADDR_W-1:0]       addr_q [READ_LATENCY];

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      for (int k = 0; k < READ_LATENCY; k++) begin
        exp_q[k]  <= '0;
        addr_q[k] <= '0;
      end
    end else begin
      valid_q[0] <= push_i;
      exp_q[0]   <= exp_i;
      addr_q[0]  <= addr_i;
      for (int k = 1; k < READ_LATENCY; k++) begin
        valid_q[k] <= valid_q[k-1];
        exp_q[k]   <= exp_q[k-1];
        addr_q[k]  <= addr_q[k-1];
      end
    end
  end

  assign valid_o = valid_q[READ_LATENCY-1];
  assign exp_o   = exp_q[READ_LATENCY-1];
  assign addr_o  = addr_q[READ_LATENCY-1];

  // "Empty" ignores the output stage: an entry there is compared this very cycle.
  generate
    if (READ_LATENCY == 1) begin : g_empty_lat1
      assign empty_o = 1'b1;
    end else begin : g_empty_latn
      assign empty_o = ~|valid_q[READ_LATENCY-2:0];
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/hello_world_qsys_ram_tester.sv
// ============================================================================
// hello_world_qsys_ram_tester : Avalon-MM fill / read-back / compare RAM tester
// Revision: 1.0
// ============================================================================
`default_nettype none

module hello_world_qsys_ram_tester
  import hello_world_qsys_ram_tester_pkg::*;
#(
  parameter int                ADDR_W       = 12,
  parameter int                DATA_W       = 32,
  parameter int                READ_LATENCY = 1,
  parameter logic [DATA_W-1:0] PAT_STEP     = DATA_W'(PAT_STEP_DEFAULT)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                check_only,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W:0]     length,
  input  logic [DATA_W-1:0]   seed,
  output logic                busy,
  output logic                done,
  output logic [15:0]         err_count,
  output logic [ADDR_W-1:0]   first_err_addr,
  output logic [ADDR_W-1:0]   avm_address,
  output logic [DATA_W/8-1:0] avm_byteenable,
  output logic                avm_chipselect,
  output logic                avm_write,
  output logic [DATA_W-1:0]   avm_writedata,
  input  logic                avm_waitrequest,
  input  logic [DATA_W-1:0]   avm_readdata
);

  state_t              state_q, state_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [DATA_W-1:0]   pat_q, pat_d;
  logic [DATA_W-1:0]   seed_q, seed_d;
  logic [15:0]         err_q, err_d;
  logic [ADDR_W-1:0]   ferr_q, ferr_d;

  logic                cs, wr, push, accept, last;
  logic                pipe_valid, pipe_empty;
  logic [DATA_W-1:0]   pipe_exp;
  logic [ADDR_W-1:0]   pipe_addr;

  assign accept = cs & ~avm_waitrequest;
  assign last   = (cnt_q == len_q - (ADDR_W+1)'(1));

  hello_world_qsys_ram_tester_rdpipe #(
    .READ_LATENCY (READ_LATENCY),
    .DATA_W       (DATA_W),
    .ADDR_W       (ADDR_W)
  ) u_rdpipe (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .exp_i   (pat_q),
    .addr_i  (addr_q),
    .valid_o (pipe_valid),
    .exp_o   (pipe_exp),
    .addr_o  (pipe_addr),
    .empty_o (pipe_empty)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    addr_d  = addr_q;
    base_d  = base_q;
    pat_d   = pat_q;
    seed_d  = seed_q;
    err_d   = err_q;
    ferr_d  = ferr_q;
    cs      = 1'b0;
    wr      = 1'b0;
    push    = 1'b0;

    if (pipe_valid && (pipe_exp != avm_readdata)) begin
      if (err_q != ERR_SAT) err_d = err_q + 16'd1;
      if (err_q == 16'd0)   ferr_d = pipe_addr;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          base_d = base_addr;
          len_d  = length;
          seed_d = seed;
          cnt_d  = '0;
          addr_d = base_addr;
          pat_d  = seed;
          err_d  = '0;
          ferr_d = '0;
          if (length == '0)    state_d = ST_DONE;
          else if (check_only) state_d = ST_READ;
          else                 state_d = ST_WRITE;
        end
      end
      ST_WRITE, ST_READ: begin
        cs   = 1'b1;
        wr   = (state_q == ST_WRITE);
        push = accept & ~wr;
        if (accept) begin
          if (last) begin
            // The write phase rewinds to word 0 for the read-back pass.
            state_d = wr ? ST_READ : ST_DRAIN;
            cnt_d   = '0;
            addr_d  = base_q;
            pat_d   = seed_q;
          end else begin
            cnt_d  = cnt_q + (ADDR_W+1)'(1);
            addr_d = addr_q + ADDR_W'(1);
            pat_d  = pat_q + PAT_STEP;
          end
        end
      end
      ST_DRAIN: begin
        if (pipe_empty) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      addr_q  <= '0;
      base_q  <= '0;
      pat_q   <= '0;
      seed_q  <= '0;
      err_q   <= '0;
      ferr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      addr_q  <= addr_d;
      base_q  <= base_d;
      pat_q   <= pat_d;
      seed_q  <= seed_d;
      err_q   <= err_d;
      ferr_q  <= ferr_d;
    end
  end

  assign busy           = (state_q != ST_IDLE);
  assign done           = (state_q == ST_DONE);
  assign err_count      = err_q;
  assign first_err_addr = ferr_q;
  assign avm_chipselect = cs;
  assign avm_write      = wr;
  assign avm_address    = cs ? addr_q : '0;
  assign avm_writedata  = wr ? pat_q : '0;
  assign avm_byteenable = {(DATA_W/8){cs}};

endmodule

`default_nettype wire

// File: tb/tb_hello_world_qsys_ram_tester.sv
// ============================================================================
// tb_hello_world_qsys_ram_tester : scoreboard bench, two DUTs (latency 1 ideal,
// latency 2 with random stalls) sharing the same run commands
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_hello_world_qsys_ram_tester;

  typedef struct {
    string       name;
    int          err;
    logic [11:0] first;
    int          cycles;
    int          xfers;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, start, check_only;
  logic [11:0] base_addr;
  logic [12:0] length;
  logic [31:0] seed;

  logic        busy0, done0, cs0, wr0, wait0, busy1, done1, cs1, wr1, wait1;
  logic [15:0] err0, err1;
  logic [11:0] ferr0, ferr1, addr0, addr1;
  logic [3:0]  be0, be1;
  logic [31:0] wd0, wd1, rd0, rd1, rd1a;

  logic [31:0] mem0 [4096];
  logic [31:0] mem1 [4096];
  bit          stall_en = 1'b1;
  bit          fault_en = 1'b0;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  int   xfer0 = 0, xfer1 = 0, xs0 = 0, xs1 = 0;
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;

  hello_world_qsys_ram_tester #(.READ_LATENCY(1)) u_dut0 (
    .clk(clk), .reset(reset), .start(start), .check_only(check_only),
    .base_addr(base_addr), .length(length), .seed(seed),
    .busy(busy0), .done(done0), .err_count(err0), .first_err_addr(ferr0),
    .avm_address(addr0), .avm_byteenable(be0), .avm_chipselect(cs0),
    .avm_write(wr0), .avm_writedata(wd0), .avm_waitrequest(wait0),
    .avm_readdata(rd0)
  );

  hello_world_qsys_ram_tester #(.READ_LATENCY(2)) u_dut1 (
    .clk(clk), .reset(reset), .start(start), .check_only(check_only),
    .base_addr(base_addr), .length(length), .seed(seed),
    .busy(busy1), .done(done1), .err_count(err1), .first_err_addr(ferr1),
    .avm_address(addr1), .avm_byteenable(be1), .avm_chipselect(cs1),
    .avm_write(wr1), .avm_writedata(wd1), .avm_waitrequest(wait1),
    .avm_readdata(rd1)
  );

  function automatic logic [31:0] rdval(input logic [31:0] d, input logic [11:0] a);
    return (fault_en && a == 12'h010) ? (d | 32'h0000_0020) : d;
  endfunction

  // RAM models: ideal latency-1 slave and stalling latency-2 slave.
  assign wait0 = 1'b0;
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    wait1 <= stall_en ? 1'($urandom_range(0, 1)) : 1'b0;
    if (cs0 && !wait0 && wr0) mem0[addr0] <= wd0;
    if (cs1 && !wait1 && wr1) mem1[addr1] <= wd1;
    if (cs0 && !wait0 && !reset) xfer0 <= xfer0 + 1;
    if (cs1 && !wait1 && !reset) xfer1 <= xfer1 + 1;
    rd0  <= rdval(mem0[addr0], addr0);
    rd1a <= rdval(mem1[addr1], addr1);
    rd1  <= rd1a;
  end

  // Monitor: pops expectations on done, and checks command hold under stall.
  logic        p_stall1 = 1'b0, p_wr1 = 1'b0;
  logic [11:0] p_addr1 = '0;
  logic [31:0] p_wd1 = '0;
  exp_t        e0, e1;

  always @(negedge clk) begin
    if (done0) begin
      if (q0.size() == 0) begin
        errors++; checks++;
        $display("FAIL dut0_unexpected_done got done=1 want done=0 at cycle %0d", cyc);
      end else begin
        e0 = q0.pop_front();
        checks++;
        if (int'(err0) != e0.err) begin
          errors++; $display("FAIL %s dut0_err_count got %0d want %0d", e0.name, err0, e0.err);
        end
        checks++;
        if (ferr0 !== e0.first) begin
          errors++; $display("FAIL %s dut0_first_err_addr got %h want %h", e0.name, ferr0, e0.first);
        end
        checks++;
        if (cyc - start_cyc + 1 != e0.cycles) begin
          errors++; $display("FAIL %s dut0_cycles got %0d want %0d", e0.name, cyc - start_cyc + 1, e0.cycles);
        end
        checks++;
        if (xfer0 - xs0 != e0.xfers) begin
          errors++; $display("FAIL %s dut0_transfers got %0d want %0d", e0.name, xfer0 - xs0, e0.xfers);
        end
      end
    end
    if (done1) begin
      if (q1.size() == 0) begin
        errors++; checks++;
        $display("FAIL dut1_unexpected_done got done=1 want done=0 at cycle %0d", cyc);
      end else begin
        e1 = q1.pop_front();
        checks++;
        if (int'(err1) != e1.err) begin
          errors++; $display("FAIL %s dut1_err_count got %0d want %0d", e1.name, err1, e1.err);
        end
        checks++;
        if (ferr1 !== e1.first) begin
          errors++; $display("FAIL %s dut1_first_err_addr got %h want %h", e1.name, ferr1, e1.first);
        end
        checks++;
        if (xfer1 - xs1 != e1.xfers) begin
          errors++; $display("FAIL %s dut1_transfers got %0d want %0d", e1.name, xfer1 - xs1, e1.xfers);
        end
      end
    end
    if (p_stall1 && !reset) begin
      checks++;
      if (!(cs1 && addr1 == p_addr1 && wr1 == p_wr1 && wd1 == p_wd1 && be1 == 4'hF)) begin
        errors++;
        $display("FAIL stall_hold got cs=%b a=%h w=%b d=%h want cs=1 a=%h w=%b d=%h",
                 cs1, addr1, wr1, wd1, p_addr1, p_wr1, p_wd1);
      end
    end
    p_stall1 = cs1 && wait1 && !reset;
    p_addr1  = addr1;
    p_wr1    = wr1;
    p_wd1    = wd1;
  end

  task automatic check_zero(input string nm);
    checks++;
    if ({busy0, done0, err0, ferr0, addr0, be0, cs0, wr0, wd0} != '0) begin
      errors++; $display("FAIL %s dut0_outputs got nonzero want all 0", nm);
    end
    checks++;
    if ({busy1, done1, err1, ferr1, addr1, be1, cs1, wr1, wd1} != '0) begin
      errors++; $display("FAIL %s dut1_outputs got nonzero want all 0", nm);
    end
  endtask

  task automatic check_word(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++; $display("FAIL %s got %h want %h", nm, got, want);
    end
  endtask

  task automatic issue(input logic [11:0] b, input logic [12:0] l, input logic [31:0] s,
                       input bit chk);
    base_addr  = b;
    length     = l;
    seed       = s;
    check_only = chk;
    start      = 1'b1;
    start_cyc  = cyc;
    xs0        = xfer0;
    xs1        = xfer1;
    @(negedge clk);
    start      = 1'b0;
  endtask

  task automatic run(input string nm, input logic [11:0] b, input logic [12:0] l,
                     input logic [31:0] s, input bit chk, input int ee,
                     input logic [11:0] ef, input int ecyc);
    exp_t e;
    e.name   = nm;
    e.err    = ee;
    e.first  = ef;
    e.cycles = ecyc;
    e.xfers  = chk ? int'(l) : 2 * int'(l);
    q0.push_back(e);
    q1.push_back(e);
    issue(b, l, s, chk);
    for (int n = 0; n < 20000 && (q0.size() != 0 || q1.size() != 0); n++) @(negedge clk);
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++; checks++;
      $display("FAIL %s timeout got pending=%0d want pending=0", nm, q0.size() + q1.size());
      q0.delete();
      q1.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem0[i] = '0;
      mem1[i] = '0;
    end
    reset = 1'b1; start = 1'b0; check_only = 1'b0;
    base_addr = '0; length = '0; seed = '0;
    repeat (3) @(negedge clk);
    check_zero("reset_state");
    reset = 1'b0;
    @(negedge clk);

    run("fill_check", 12'h000, 13'd16, 32'h0, 1'b0, 0, 12'h000, 35);
    check_word("fill_word1_dut0", mem0[1], 32'h9E37_79B9);
    check_word("fill_word1_dut1", mem1[1], 32'h9E37_79B9);

    run("wrap", 12'd4094, 13'd4, 32'h0000_1000, 1'b0, 0, 12'h000, 11);
    check_word("wrap_4094", mem0[4094], 32'h0000_1000);
    check_word("wrap_4095", mem0[4095], 32'h9E37_89B9);
    check_word("wrap_0",    mem0[0],    32'h3C6F_0372);
    check_word("wrap_1",    mem0[1],    32'hDAA6_7D2B);
    check_word("wrap_1_dut1", mem1[1],  32'hDAA6_7D2B);

    fault_en = 1'b1;
    run("fault", 12'h008, 13'd32, 32'h0, 1'b0, 1, 12'h010, 67);
    fault_en = 1'b0;

    run("len0", 12'h123, 13'd0, 32'hABCD_0123, 1'b0, 0, 12'h000, 2);

    // Abort a run in its read phase; no done may follow.
    issue(12'h100, 13'd16, 32'h5555_0000, 1'b0);
    for (int n = 0; n < 200 && !(cs0 && !wr0); n++) @(negedge clk);
    checks++;
    if (!(cs0 && !wr0)) begin
      errors++; $display("FAIL abort_reach_read got cs=%b w=%b want cs=1 w=0", cs0, wr0);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_zero("reset_mid_read");
    reset = 1'b0;
    repeat (60) @(negedge clk);

    run("check_only_blank", 12'h800, 13'd8, 32'h1234_5678, 1'b1, 8, 12'h800, 11);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
